// File: rtl/sensor_frame_writer.sv
// sensor_frame_writer: assembles 4-word sensor frames (VCO, humidity,
// pressure, temperature) from a valid/ready stream and commits each complete
// frame as one sample row across four parallel buffers. Readback is
// registered, and rows that have not been committed read back as zero.
`timescale 1ns/1ps

module sensor_frame_writer #(
    parameter int width = 32,
    parameter int DEPTH = 600
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [width-1:0] s_data,
    input  logic             s_last,
    input  logic [11:0]      rd_addr,
    output logic [width-1:0] rd_vco,
    output logic [width-1:0] rd_hum,
    output logic [width-1:0] rd_pres,
    output logic [width-1:0] rd_temp,
    output logic [9:0]       wr_count,
    output logic             full,
    output logic             frame_err
);

    localparam int         AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [9:0] DEPTH_CNT  = 10'(DEPTH);
    localparam logic [11:0] DEPTH_ADR = 12'(DEPTH);

    typedef enum logic [2:0] {
        W_VCO,
        W_HUM,
        W_PRES,
        W_TEMP,
        DROP,
        FULL
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic             w_accept;
    logic             w_commit;
    logic             w_frame_bad;
    logic             w_rd_hit;
    logic [AW-1:0]    w_wr_idx;
    logic [AW-1:0]    w_rd_idx;

    logic [9:0]       r_count;
    logic             r_frame_err;
    logic [width-1:0] r_stg_vco;
    logic [width-1:0] r_stg_hum;
    logic [width-1:0] r_stg_pres;

    logic [width-1:0] r_mem_vco  [DEPTH];
    logic [width-1:0] r_mem_hum  [DEPTH];
    logic [width-1:0] r_mem_pres [DEPTH];
    logic [width-1:0] r_mem_temp [DEPTH];

    // Ready is dropped as soon as rst or clear is seen so that a word
    // presented alongside either is never half-accepted.
    assign s_ready  = !rst && !clear && (r_state != FULL);
    assign w_accept = s_valid && s_ready;

    assign w_wr_idx = r_count[AW-1:0];
    assign w_rd_idx = rd_addr[AW-1:0];

    // A read is only valid for rows already committed before this edge, so a
    // read aimed at the row being written this cycle still returns zero.
    assign w_rd_hit = (rd_addr < {2'b00, r_count}) && (rd_addr < DEPTH_ADR);

    assign wr_count  = r_count;
    assign full      = (r_count == DEPTH_CNT);
    assign frame_err = r_frame_err;

    // Next-state decode: walks the frame order on each accepted word and
    // flags short or long frames.
    always_comb begin
        w_state_nxt = r_state;
        w_commit    = 1'b0;
        w_frame_bad = 1'b0;
        if (w_accept) begin
            case (r_state)
                W_VCO: begin
                    if (s_last) begin
                        w_frame_bad = 1'b1;
                        w_state_nxt = W_VCO;
                    end else begin
                        w_state_nxt = W_HUM;
                    end
                end
                W_HUM: begin
                    if (s_last) begin
                        w_frame_bad = 1'b1;
                        w_state_nxt = W_VCO;
                    end else begin
                        w_state_nxt = W_PRES;
                    end
                end
                W_PRES: begin
                    if (s_last) begin
                        w_frame_bad = 1'b1;
                        w_state_nxt = W_VCO;
                    end else begin
                        w_state_nxt = W_TEMP;
                    end
                end
                W_TEMP: begin
                    if (s_last) begin
                        w_commit    = 1'b1;
                        w_state_nxt = ((r_count + 10'd1) == DEPTH_CNT) ? FULL : W_VCO;
                    end else begin
                        // Too many words: throw the rest away until s_last.
                        w_frame_bad = 1'b1;
                        w_state_nxt = DROP;
                    end
                end
                DROP: begin
                    if (s_last) begin
                        w_state_nxt = W_VCO;
                    end
                end
                FULL: begin
                    w_state_nxt = FULL;
                end
                default: begin
                    w_state_nxt = W_VCO;
                end
            endcase
        end
    end

    // State register; clear restarts frame assembly like rst does.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_state <= W_VCO;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Staging registers hold the first three words until the frame completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stg_vco  <= '0;
            r_stg_hum  <= '0;
            r_stg_pres <= '0;
        end else if (w_accept) begin
            case (r_state)
                W_VCO:   r_stg_vco  <= s_data;
                W_HUM:   r_stg_hum  <= s_data;
                W_PRES:  r_stg_pres <= s_data;
                default: ;
            endcase
        end
    end

    // Committed-row counter and sticky framing error.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_count     <= '0;
            r_frame_err <= 1'b0;
        end else begin
            if (w_commit) begin
                r_count <= r_count + 10'd1;
            end
            if (w_frame_bad) begin
                r_frame_err <= 1'b1;
            end
        end
    end

    // Buffer write: the whole row lands in one edge; contents survive rst/clear.
    always_ff @(posedge clk) begin
        if (w_commit) begin
            r_mem_vco[w_wr_idx]  <= r_stg_vco;
            r_mem_hum[w_wr_idx]  <= r_stg_hum;
            r_mem_pres[w_wr_idx] <= r_stg_pres;
            r_mem_temp[w_wr_idx] <= s_data;
        end
    end

    // Registered readback, zero for rows that are not (yet) committed.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_vco  <= '0;
            rd_hum  <= '0;
            rd_pres <= '0;
            rd_temp <= '0;
        end else if (w_rd_hit) begin
            rd_vco  <= r_mem_vco[w_rd_idx];
            rd_hum  <= r_mem_hum[w_rd_idx];
            rd_pres <= r_mem_pres[w_rd_idx];
            rd_temp <= r_mem_temp[w_rd_idx];
        end else begin
            rd_vco  <= '0;
            rd_hum  <= '0;
            rd_pres <= '0;
            rd_temp <= '0;
        end
    end

endmodule

// File: tb/tb_sensor_frame_writer.sv
// Bench for sensor_frame_writer: directed frames, with expected readback and
// status pushed into queues and checked by an independent monitor.
`timescale 1ns/1ps

module tb_sensor_frame_writer;

    localparam int W = 32;
    localparam int D = 600;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clear = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [W-1:0]  s_data = '0;
    logic          s_last = 1'b0;
    logic [11:0]   rd_addr = '0;
    logic [W-1:0]  rd_vco, rd_hum, rd_pres, rd_temp;
    logic [9:0]    wr_count;
    logic          full;
    logic          frame_err;

    typedef struct {
        logic [31:0] v;
        logic [31:0] h;
        logic [31:0] p;
        logic [31:0] t;
    } rd_t;

    typedef struct {
        int cnt;
        bit f;
        bit e;
        bit r;
    } st_t;

    rd_t rd_q[$];
    st_t st_q[$];
    bit  rd_req = 1'b0;
    bit  st_req = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    sensor_frame_writer #(.width(W), .DEPTH(D)) dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_last    (s_last),
        .rd_addr   (rd_addr),
        .rd_vco    (rd_vco),
        .rd_hum    (rd_hum),
        .rd_pres   (rd_pres),
        .rd_temp   (rd_temp),
        .wr_count  (wr_count),
        .full      (full),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endfunction

    function automatic rd_t mk(logic [31:0] v, logic [31:0] h, logic [31:0] p, logic [31:0] t);
        rd_t x;
        x.v = v; x.h = h; x.p = p; x.t = t;
        return x;
    endfunction

    // Monitor: whenever a read or status probe was presented at an edge,
    // pop the expectation and compare just after that edge.
    initial begin
        bit take_rd;
        bit take_st;
        rd_t er;
        st_t es;
        forever begin
            @(posedge clk);
            take_rd = rd_req;
            take_st = st_req;
            #1;
            if (take_rd) begin
                if (rd_q.size() == 0) begin
                    chk("rd_queue_underflow", 32'd1, 32'd0);
                end else begin
                    er = rd_q.pop_front();
                    chk("rd_vco",  rd_vco,  er.v);
                    chk("rd_hum",  rd_hum,  er.h);
                    chk("rd_pres", rd_pres, er.p);
                    chk("rd_temp", rd_temp, er.t);
                end
            end
            if (take_st) begin
                if (st_q.size() == 0) begin
                    chk("st_queue_underflow", 32'd1, 32'd0);
                end else begin
                    es = st_q.pop_front();
                    chk("wr_count",  {22'd0, wr_count}, es.cnt);
                    chk("full",      {31'd0, full},      {31'd0, es.f});
                    chk("frame_err", {31'd0, frame_err}, {31'd0, es.e});
                    chk("s_ready",   {31'd0, s_ready},   {31'd0, es.r});
                end
            end
        end
    end

    task automatic send(input logic [31:0] d, input logic last);
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic frame4(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] c, input logic [31:0] d);
        send(a, 1'b0);
        send(b, 1'b0);
        send(c, 1'b0);
        send(d, 1'b1);
    endtask

    task automatic rd(input logic [11:0] addr, input rd_t exp);
        @(negedge clk);
        rd_addr = addr;
        rd_req  = 1'b1;
        rd_q.push_back(exp);
        @(negedge clk);
        rd_req  = 1'b0;
    endtask

    task automatic status(input int cnt, input bit f, input bit e, input bit r);
        st_t s;
        s.cnt = cnt; s.f = f; s.e = e; s.r = r;
        @(negedge clk);
        st_req = 1'b1;
        st_q.push_back(s);
        @(negedge clk);
        st_req = 1'b0;
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    // Watchdog so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    // Stimulus
    initial begin
        rd_t z;
        z = mk(32'h0, 32'h0, 32'h0, 32'h0);

        // Reset state
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_rd_vco", rd_vco, 32'h0);
        chk("rst_rd_temp", rd_temp, 32'h0);
        status(0, 1'b0, 1'b0, 1'b1);

        // Single good frame
        frame4(32'h11, 32'h22, 32'h33, 32'h44);
        status(1, 1'b0, 1'b0, 1'b1);
        rd(12'd0, mk(32'h11, 32'h22, 32'h33, 32'h44));
        rd(12'd1, z);

        // Short frame, then a good frame at the old count
        send(32'h55, 1'b0);
        send(32'h66, 1'b1);
        status(1, 1'b0, 1'b1, 1'b1);
        frame4(32'hA1, 32'hA2, 32'hA3, 32'hA4);
        status(2, 1'b0, 1'b1, 1'b1);
        rd(12'd1, mk(32'hA1, 32'hA2, 32'hA3, 32'hA4));

        // Long frame: 6 words, last on the 6th
        send(32'h71, 1'b0);
        send(32'h72, 1'b0);
        send(32'h73, 1'b0);
        send(32'h74, 1'b0);
        send(32'h75, 1'b0);
        send(32'h76, 1'b1);
        status(2, 1'b0, 1'b1, 1'b1);

        // Good frame whose commit coincides with a read of the same row
        send(32'hB1, 1'b0);
        send(32'hB2, 1'b0);
        send(32'hB3, 1'b0);
        @(negedge clk);
        s_valid = 1'b1; s_data = 32'hB4; s_last = 1'b1;
        rd_addr = 12'd2; rd_req = 1'b1; rd_q.push_back(z);
        @(negedge clk);
        s_valid = 1'b0; s_last = 1'b0; rd_req = 1'b0;
        rd(12'd2, mk(32'hB1, 32'hB2, 32'hB3, 32'hB4));
        status(3, 1'b0, 1'b1, 1'b1);

        // Clear with a word presented in the same cycle
        @(negedge clk);
        clear = 1'b1; s_valid = 1'b1; s_data = 32'h99; s_last = 1'b1;
        #1;
        chk("clear_s_ready", {31'd0, s_ready}, 32'd0);
        @(negedge clk);
        clear = 1'b0; s_valid = 1'b0; s_last = 1'b0;
        status(0, 1'b0, 1'b0, 1'b1);
        rd(12'd0, z);
        frame4(32'hC1, 32'hC2, 32'hC3, 32'hC4);
        status(1, 1'b0, 1'b0, 1'b1);
        rd(12'd0, mk(32'hC1, 32'hC2, 32'hC3, 32'hC4));

        // Fill rows 1..599
        for (int k = 1; k < D; k++) begin
            frame4(32'hA000_0000 | k, 32'hB000_0000 | k,
                   32'hC000_0000 | k, 32'hD000_0000 | k);
        end
        status(600, 1'b1, 1'b0, 1'b0);

        // 601st frame must not be accepted
        @(negedge clk);
        s_valid = 1'b1; s_data = 32'hEE; s_last = 1'b0;
        #1;
        chk("full_s_ready", {31'd0, s_ready}, 32'd0);
        repeat (4) @(negedge clk);
        s_data = 32'hEF; s_last = 1'b1;
        repeat (2) @(negedge clk);
        s_valid = 1'b0; s_last = 1'b0;
        status(600, 1'b1, 1'b0, 1'b0);
        rd(12'd599, mk(32'hA000_0257, 32'hB000_0257, 32'hC000_0257, 32'hD000_0257));
        rd(12'd600, z);
        rd(12'd0, mk(32'hC1, 32'hC2, 32'hC3, 32'hC4));

        // Clear out of FULL, commit one frame, then reset mid-frame
        do_clear();
        status(0, 1'b0, 1'b0, 1'b1);
        frame4(32'hE1, 32'hE2, 32'hE3, 32'hE4);
        rd(12'd0, mk(32'hE1, 32'hE2, 32'hE3, 32'hE4));
        send(32'hF1, 1'b0);
        send(32'hF2, 1'b0);
        send(32'hF3, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_s_ready", {31'd0, s_ready}, 32'd0);
        @(posedge clk);
        #1;
        chk("rst_rd_vco_mid", rd_vco, 32'h0);
        chk("rst_rd_hum_mid", rd_hum, 32'h0);
        chk("rst_rd_pres_mid", rd_pres, 32'h0);
        chk("rst_rd_temp_mid", rd_temp, 32'h0);
        chk("rst_wr_count_mid", {22'd0, wr_count}, 32'd0);
        chk("rst_frame_err_mid", {31'd0, frame_err}, 32'd0);
        chk("rst_full_mid", {31'd0, full}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        frame4(32'hD1, 32'hD2, 32'hD3, 32'hD4);
        status(1, 1'b0, 1'b0, 1'b1);
        rd(12'd0, mk(32'hD1, 32'hD2, 32'hD3, 32'hD4));

        repeat (3) @(negedge clk);
        chk("rd_queue_drained", rd_q.size(), 32'd0);
        chk("st_queue_drained", st_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sensor_frame_writer.md
SENSOR_FRAME_WRITER -- requirements
Module: sensor_frame_writer

Interface
REQ-001 SHALL have parameter width, default 32, meaning the sensor word width in bits.
REQ-002 SHALL have parameter DEPTH, default 600, meaning the number of sample entries per sensor buffer.
REQ-003 SHALL have one clock and a synchronous, active-high reset: clk input 1, rising-edge clock for all logic.
REQ-004 SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-005 SHALL have port clear, input, 1 bit: synchronous buffer flush (pointer, count and error only).
REQ-006 SHALL have port s_valid, input, 1 bit: the upstream word is valid.
REQ-007 SHALL have port s_ready, output, 1 bit: the block accepts a word this cycle.
REQ-008 SHALL have port s_data, input, width bits: the sensor word.
REQ-009 SHALL have port s_last, input, 1 bit: marks the final word of a frame.
REQ-010 SHALL have port rd_addr, input, 12 bits: the sample index for readback.
REQ-011 SHALL have ports rd_vco, rd_hum, rd_pres and rd_temp, each output, width bits: the registered readback data.
REQ-012 SHALL have port wr_count, output, 10 bits: the number of committed samples, range 0..DEPTH.
REQ-013 SHALL have port full, output, 1 bit: wr_count == DEPTH.
REQ-014 SHALL have port frame_err, output, 1 bit: sticky framing-error flag.

Function
REQ-015 SHALL hold four buffers of DEPTH x width (VCO, Humidity, Pressure, Temperature), with one write port and one read port each.
REQ-016 SHALL accept a word only on the cycle where s_valid && s_ready are both high.
REQ-017 SHALL follow the frame order VCO, Humidity, Pressure, Temperature; the FSM states are W_VCO, W_HUM, W_PRES, W_TEMP, DROP and FULL.
REQ-018 SHALL advance W_VCO->W_HUM->W_PRES->W_TEMP on each accepted word with s_last=0, latching each word into its staging register.
REQ-019 SHALL, on a word accepted in W_TEMP with s_last=1, write all four staged/current words at address wr_count in the same edge, increment wr_count, and go to W_VCO, or to FULL if the new wr_count == DEPTH.
REQ-020 SHALL, on s_last=1 accepted in W_VCO/W_HUM/W_PRES (short frame), set frame_err, discard the partial frame, and go to W_VCO.
REQ-021 SHALL, on s_last=0 accepted in W_TEMP (long frame), set frame_err, discard the frame, and go to DROP.
REQ-022 SHALL, in DROP, accept and discard words and return to W_VCO after the word carrying s_last=1.
REQ-023 SHALL drive s_ready combinationally as: 1 in W_*/DROP, 0 in FULL, and 0 whenever rst or clear is high.
REQ-024 SHALL hold FULL with s_ready=0 until clear; the buffers are never overwritten (no wrap-around).
REQ-025 SHALL, on clear, set wr_count=0, full=0 and frame_err=0, go to state W_VCO, discard any partial frame, and leave buffer contents unchanged.
REQ-026 SHALL give clear priority over a simultaneous handshake; the word is not accepted because s_ready=0.
REQ-027 SHALL register readback with 1-cycle latency: the rd_* outputs at edge N+1 reflect rd_addr at edge N.
REQ-028 SHALL return zero on all four rd_* outputs when rd_addr >= wr_count or rd_addr >= DEPTH.
REQ-029 SHALL evaluate the read against the pre-edge wr_count when a read hits the address being committed in the same cycle, so it returns zero.
REQ-030 SHALL store words unmodified (no scaling or sign handling); signed fixed-point interpretation belongs to the consumer.

Reset
REQ-031 SHALL, on rst, set state W_VCO, wr_count=0, full=0, frame_err=0, all rd_* outputs = 0, and clear the staging registers.
REQ-032 SHALL abandon any in-progress frame on rst mid-frame; buffer contents are not reset.
REQ-033 SHALL give rst priority over clear and over the handshake.

Verification
REQ-034 SHALL cover a single frame: 0x11,0x22,0x33,0x44 (last on 4th) -> wr_count=1; rd_addr=0 gives one cycle later rd_vco=0x11, rd_hum=0x22, rd_pres=0x33, rd_temp=0x44.
REQ-035 SHALL cover a short frame: 2 words with last on the 2nd -> frame_err=1, wr_count unchanged; the next good frame commits at the old wr_count.
REQ-036 SHALL cover a long frame: 6 words with last on the 6th -> frame_err=1, words 5-6 dropped, FSM in W_VCO, wr_count unchanged.
REQ-037 SHALL cover fill: 600 good frames -> full=1, s_ready=0, wr_count=600; a 601st frame is not accepted; rd_addr=599 returns the last frame; rd_addr=600 returns 0.
REQ-038 SHALL cover clear with s_valid high in the same cycle -> word not accepted, wr_count=0, frame_err=0; rd_addr=0 returns 0; the next frame lands at address 0.
REQ-039 SHALL cover rst after 3 accepted words -> all outputs 0; a following full frame commits at address 0 with correct order.
